bootram_ctrl: RTL



---
 rtl/bootram_ctrl_if.sv | 50 +++++
 rtl/bootram_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bootram_ctrl_if.sv
// Boot RAM controller bus bundle: CPU native bus, UART loader port, and the
// strobes/data shared by the four BSRAM byte lanes.
// slave  = the controller side (accepts requests, drives the lanes).
// master = requesters plus the RAM lanes (drive requests, consume responses).
interface bootram_ctrl_if #(
  parameter int WORD_AW = 11
);
  // CPU native memory bus
  logic                 mem_valid;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic                 mem_ready;
  logic [31:0]          mem_rdata;
  // byte-wide loader/debug port
  logic                 ld_req;
  logic                 ld_we;
  logic [WORD_AW+1:0]   ld_addr;
  logic [7:0]           ld_wdata;
  logic                 ld_ack;
  logic [7:0]           ld_rdata;
  // four 2Kx8 lanes, lane n = byte n of the word
  logic [3:0]           ram_ce;
  logic [3:0]           ram_wre;
  logic [WORD_AW-1:0]   ram_ad;
  logic [31:0]          ram_din;
  logic [31:0]          ram_dout;
  logic                 ram_oce;
  logic                 ram_reset;
  // status
  logic                 busy;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  ram_dout,
    output mem_ready, mem_rdata, ld_ack, ld_rdata,
    output ram_ce, ram_wre, ram_ad, ram_din, ram_oce, ram_reset,
    output busy
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output ram_dout,
    input  mem_ready, mem_rdata, ld_ack, ld_rdata,
    input  ram_ce, ram_wre, ram_ad, ram_din, ram_oce, ram_reset,
    input  busy
  );
endinterface

// File: rtl/bootram_ctrl.sv
// Boot RAM sequencer/arbiter: shares four BSRAM byte lanes between the CPU bus and the UART loader.
// Latency: request seen in IDLE at cycle N -> lane strobes at N+1 -> ready/ack pulse at N+2; next grant at N+3.
// Backpressure: requesters hold their request until the one-cycle ready/ack pulse; one access in flight at a time.
// Ports: clk, resetn (async active-low), bus (bootram_ctrl_if.slave: CPU bus, loader port, lane strobes, busy).
module bootram_ctrl #(
  parameter int WORD_AW       = 11,
  parameter bit LD_FIXED_PRIO = 1'b0
) (
  input logic           clk,
  input logic           resetn,
  bootram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  logic               gnt_cpu;      // 1: CPU owns the current access, 0: loader
  logic               last_ld;      // arbitration pointer: 1 = loader won the last contested decision
  logic               wr_q;         // current access is a write
  logic [1:0]         lane_q;       // loader byte lane of the current access
  logic               mem_ready_q;
  logic               ld_ack_q;
  logic [7:0]         ld_rdata_q;
  logic [3:0]         ram_ce_q;
  logic [3:0]         ram_wre_q;
  logic [WORD_AW-1:0] ram_ad_q;
  logic [31:0]        ram_din_q;

  logic               any_req;
  logic               pick_cpu;
  logic               cpu_wr;
  logic [3:0]         ld_lane_oh;
  logic               unused_addr;

  assign any_req    = bus.mem_valid | bus.ld_req;
  assign cpu_wr     = |bus.mem_wstrb;
  assign ld_lane_oh = 4'b0001 << bus.ld_addr[1:0];

  // The CPU wins when it is alone, or on a tie when round-robin is selected
  // and the loader took the previous tie.
  assign pick_cpu = bus.mem_valid &&
                    (!bus.ld_req || (!LD_FIXED_PRIO && last_ld));

  // Only the word-address field of the CPU byte address reaches the RAM.
  assign unused_addr = ^{bus.mem_addr[31:WORD_AW+2], bus.mem_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gnt_cpu     <= 1'b0;
      last_ld     <= 1'b1;
      wr_q        <= 1'b0;
      lane_q      <= 2'd0;
      mem_ready_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      ld_rdata_q  <= 8'h00;
      ram_ce_q    <= 4'h0;
      ram_wre_q   <= 4'h0;
      ram_ad_q    <= '0;
      ram_din_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready_q <= 1'b0;
          ld_ack_q    <= 1'b0;
          if (any_req) begin
            state   <= ACCESS;
            gnt_cpu <= pick_cpu;
            // The pointer only moves on contested decisions, so consecutive
            // simultaneous pairs alternate their winner.
            if (bus.mem_valid && bus.ld_req) begin
              last_ld <= !pick_cpu;
            end
            if (pick_cpu) begin
              ram_ad_q  <= bus.mem_addr[WORD_AW+1:2];
              ram_din_q <= bus.mem_wdata;
              wr_q      <= cpu_wr;
              ram_ce_q  <= cpu_wr ? bus.mem_wstrb : 4'hF;
              ram_wre_q <= bus.mem_wstrb;
            end else begin
              ram_ad_q  <= bus.ld_addr[WORD_AW+1:2];
              ram_din_q <= {4{bus.ld_wdata}};
              wr_q      <= bus.ld_we;
              lane_q    <= bus.ld_addr[1:0];
              ram_ce_q  <= ld_lane_oh;
              ram_wre_q <= bus.ld_we ? ld_lane_oh : 4'h0;
            end
          end
        end

        ACCESS: begin
          // RAM samples the strobes at this edge; drop them for RESP.
          ram_ce_q    <= 4'h0;
          ram_wre_q   <= 4'h0;
          mem_ready_q <= gnt_cpu;
          ld_ack_q    <= !gnt_cpu;
          state       <= RESP;
        end

        RESP: begin
          mem_ready_q <= 1'b0;
          ld_ack_q    <= 1'b0;
          // Loader read byte is captured here and held until the next loader read.
          if (!gnt_cpu && !wr_q) begin
            ld_rdata_q <= bus.ram_dout[{lane_q, 3'b000} +: 8];
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_ready = mem_ready_q;
  // ram_dout is only valid in RESP; the response word is gated by the
  // registered ready so it is zero at all other times and on writes.
  assign bus.mem_rdata = (mem_ready_q && !wr_q) ? bus.ram_dout : 32'h0;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.ram_ce    = ram_ce_q;
  assign bus.ram_wre   = ram_wre_q;
  assign bus.ram_ad    = ram_ad_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = 1'b0;
  assign bus.busy      = (state != IDLE);

endmodule
